// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8:1 mux channel.
// Holds a grant until done, owner withdrawal, or the MAX_HOLD limit.
module rr_mux_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [7:0] grant_q;
    logic [2:0] sel_q;
    logic [2:0] ptr_q;
    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    logic       pick_valid;
    logic [2:0] pick_idx;
    logic [2:0] scan_idx;
    logic       rel_owner;
    logic       rel_limit;
    logic       rel_any;

    // Scan ptr+1, ptr+2, ... so the last owner has lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int i = 1; i <= 8; i++) begin
            scan_idx = ptr_q + 3'(i);
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        rel_owner = done || !req[sel_q];
        rel_limit = (hold_cnt_q == 8'(MAX_HOLD - 1));
        rel_any   = rel_owner || rel_limit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pick_valid) state_d = StGrant;
            StGrant: if (rel_any) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= 8'h00;
            sel_q      <= 3'd0;
            ptr_q      <= 3'd7;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q    <= 8'b1 << pick_idx;
                        sel_q      <= pick_idx;
                        ptr_q      <= pick_idx;
                        hold_cnt_q <= 8'd0;
                    end
                end
                StGrant: begin
                    if (rel_any) begin
                        grant_q   <= 8'h00;
                        // Done/withdraw outrank the limit for reporting purposes.
                        timeout_q <= rel_limit && !rel_owner;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: grant_q <= 8'h00;
            endcase
        end
    end

    always_comb begin
        grant   = grant_q;
        sel     = sel_q;
        busy    = (state_q == StGrant);
        timeout = timeout_q;
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_sel:     assert property (@(posedge clk) disable iff (rst)
                                      (grant != 8'h00) |-> (grant == (8'b1 << sel)));
    a_busy_grant:    assert property (@(posedge clk) disable iff (rst)
                                      busy == (grant != 8'h00));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with hand-computed expectations (MAX_HOLD = 16).
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    int n_cmp;
    int n_bad;

    rr_mux_arbiter #(.MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles;
        n_cmp = 0;
        n_bad = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_grant", grant, 8'h00);
        check_eq("rst_sel", 8'(sel), 8'd0);
        check_eq("rst_busy", 8'(busy), 8'd0);
        check_eq("rst_timeout", 8'(timeout), 8'd0);

        // Single requester, done release
        req = 8'h01;
        tick();
        check_eq("single_grant", grant, 8'h01);
        check_eq("single_sel", 8'(sel), 8'd0);
        check_eq("single_busy", 8'(busy), 8'd1);
        done = 1'b1;
        tick();
        check_eq("done_rel_grant", grant, 8'h00);
        check_eq("done_rel_timeout", 8'(timeout), 8'd0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        // done while idle has no effect
        done = 1'b1;
        tick();
        check_eq("idle_done_busy", 8'(busy), 8'd0);
        done = 1'b0;

        // Full rotation from reset pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check_eq($sformatf("rot_grant%0d", k), grant, 8'b1 << (k % 8));
            check_eq($sformatf("rot_sel%0d", k), 8'(sel), 8'(k % 8));
            done = 1'b1;
            tick();
            check_eq($sformatf("rot_gap%0d", k), grant, 8'h00);
            done = 1'b0;
        end
        req = 8'h00;
        tick();

        // Hold limit: 16 cycles of grant then timeout pulse
        req = 8'h10;
        tick();
        cycles = (grant == 8'h10) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant == 8'h10) cycles++;
            else break;
        end
        check_eq("hold_cycles", 8'(cycles), 8'd16);
        check_eq("hold_rel_grant", grant, 8'h00);
        check_eq("hold_timeout", 8'(timeout), 8'd1);
        check_eq("hold_busy", 8'(busy), 8'd0);
        tick();
        check_eq("hold_regrant", grant, 8'h10);
        check_eq("hold_timeout_pulse", 8'(timeout), 8'd0);
        req = 8'h00;
        tick();
        check_eq("withdraw4_grant", grant, 8'h00);
        check_eq("withdraw4_timeout", 8'(timeout), 8'd0);

        // Owner 3 withdraws, source 5 follows (ptr=4)
        req = 8'h08;
        tick();
        check_eq("own3_grant", grant, 8'h08);
        req = 8'h28;
        tick();
        check_eq("own3_keep", grant, 8'h08);
        req = 8'h20;
        tick();
        check_eq("own3_rel", grant, 8'h00);
        tick();
        check_eq("src5_grant", grant, 8'h20);
        check_eq("src5_sel", 8'(sel), 8'd5);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();

        // done coincides with hold limit (ptr=5, scan reaches 4)
        req = 8'h10;
        tick();
        check_eq("both_grant", grant, 8'h10);
        for (int i = 0; i < 15; i++) tick();
        check_eq("both_still", grant, 8'h10);
        done = 1'b1;
        tick();
        check_eq("both_rel", grant, 8'h00);
        check_eq("both_timeout", 8'(timeout), 8'd0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        // Pointer wrap: ptr=6, req=41 -> source 0
        req = 8'h40;
        tick();
        check_eq("src6_grant", grant, 8'h40);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h41;
        tick();
        check_eq("wrap_grant", grant, 8'h01);
        check_eq("wrap_sel", 8'(sel), 8'd0);

        // Reset mid-grant
        rst = 1'b1;
        tick();
        check_eq("midrst_grant", grant, 8'h00);
        check_eq("midrst_sel", 8'(sel), 8'd0);
        check_eq("midrst_busy", 8'(busy), 8'd0);
        rst = 1'b0;
        tick();
        check_eq("postrst_grant", grant, 8'h01);
        check_eq("postrst_timeout", 8'(timeout), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux output channel among eight requesters.
- Grants one requester at a time, drives the 3-bit mux select and a one-hot grant vector, and holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits directly upstream of the 8:1 mux select inputs (sel[2] = MSB select, sel[0] = LSB select).

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold a grant before forced release; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request per source; bit i = source i (mux data input ai)
- done  input  1  owner finished its transfer; sampled only in GRANT
- grant  output  8  one-hot grant, registered; 8'h00 when no owner
- sel  output  3  binary index of current/last owner, drives mux select
- busy  output  1  high while in GRANT
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- One clock: clk. Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
- Reset values: grant=8'h00, sel=3'd0, busy=0, timeout=0, state=IDLE, ptr=3'd7, hold_cnt=0.
- ptr is the index of the last granted source. Reset value 7 gives source 0 first priority.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, choose the first set bit scanning ptr+1, ptr+2, ... mod 8.
  - On the next edge: grant=onehot(k), sel=k, ptr=k, busy=1, hold_cnt=0, state=GRANT.
  - If req==0, stay in IDLE. grant stays 0; sel keeps its last value.
- GRANT: release when any of the following holds on an edge. The state then returns to IDLE, grant=8'h00, busy=0, and sel and ptr are unchanged.
  - (a) done=1
  - (b) req[sel]=0, meaning the owner withdrew
  - (c) hold_cnt==MAX_HOLD-1
- If none holds, hold_cnt increments (8-bit, saturating not needed given the range).
- Precedence: done or withdraw takes priority over timeout. timeout=1 in the cycle after release only if (c) alone caused it; otherwise timeout=0.
- Latency:
  - A request seen in IDLE at edge N produces grant at N+1.
  - A release condition at edge M produces grant=0 at M+1.
  - The earliest re-grant is at M+2. This gives a mandatory one-cycle gap with no grant, so the mux output is never switched mid-transfer.
- Maximum grant length is MAX_HOLD cycles of grant high.
- Requests from non-owners during GRANT are ignored. They are not latched and are re-evaluated at IDLE.
- Simultaneous requests are resolved by the rotating pointer only; there is no fixed priority after reset.
- Invariants checked by assertion:
  - grant is 0 or one-hot.
  - When grant!=0, grant==(1<<sel).
  - busy==(grant!=0).
- Reset mid-grant: the next edge forces all reset values; ptr returns to 7.
- done asserted while in IDLE has no effect.

Test Plan:
- Reset, then req=8'b0000_0001 → grant=8'h01, sel=0, busy=1 one cycle after req. done pulse → grant=8'h00 next cycle, timeout=0.
- req=8'hFF held, done pulsed each GRANT cycle after 1 cycle:
  - Grant sequence is 0,1,2,...,7,0 (sel increments mod 8).
  - Each grant is separated by exactly one idle cycle.
- MAX_HOLD=16, req=8'h10 held, done=0:
  - grant=8'h10 for exactly 16 cycles, then 8'h00.
  - timeout=1 for one cycle, busy=0.
  - Re-grant to source 4 two cycles after release (only requester).
- Owner 3 granted, req=8'h28; drop req[3] → release next cycle; next grant=8'h20 (source 5), sel=5.
- done=1 and the hold limit reached on the same edge → release with timeout=0.
- ptr wrap and reset:
  - With ptr=6 and req=8'h41, the next grant goes to source 0 (scan 7,0).
  - Assert rst during GRANT → grant=8'h00, sel=0, busy=0 next edge.
  - Then req=8'h41 → source 0 is granted (ptr reset to 7).
